// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the minion endpoint and its master-side
// counterpart.
//   state_t    : frame-level FSM states (IDLE, ACTIVE, HOLD)
//   spi_cpol   : clock polarity; sclk idles low
//   spi_cpha   : clock phase; data is sampled on the leading (rising) edge
// No ports; this is a package.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic spi_cpol = 1'b0;
   localparam logic spi_cpha = 1'b0;

endpackage

// File: rtl/spi_minion_if.sv
// Bundle of SPI pin signals and parallel val/rdy channels for spi_minion.
// Ports (via modports):
//   cs, sclk, mosi     : pins driven by the external SPI master
//   miso               : pin driven back by the minion
//   recv_msg/val/rdy   : word to transmit in the next frame (into the minion)
//   send_msg/val/rdy   : last complete received frame (out of the minion)
//   overflow           : sticky flag, a received frame was dropped
// slave modport is the minion's view; master modport is the surrounding logic.
interface spi_minion_if #(parameter int nbits = 8);

   logic             cs;
   logic             sclk;
   logic             mosi;
   logic             miso;
   logic [nbits-1:0] recv_msg;
   logic             recv_val;
   logic             recv_rdy;
   logic [nbits-1:0] send_msg;
   logic             send_val;
   logic             send_rdy;
   logic             overflow;

   modport slave (
      input  cs, sclk, mosi, recv_msg, recv_val, send_rdy,
      output miso, recv_rdy, send_msg, send_val, overflow
   );

   modport master (
      output cs, sclk, mosi, recv_msg, recv_val, send_rdy,
      input  miso, recv_rdy, send_msg, send_val, overflow
   );

endinterface

// File: rtl/spi_minion_sync.sv
// Brings one asynchronous SPI pin into the clk domain.
// Two flops resolve metastability, a third flop delays the synchronized
// level by one cycle so single-cycle edge pulses can be formed.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   din        : raw asynchronous pin
//   sync       : synchronized level (second flop)
//   rise, fall : one-cycle pulses on a synchronized rising / falling edge
module spi_minion_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/vc_BasicCounter.sv
// Basic up-counter with synchronous clear, saturating at a maximum value.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   clear         : return count to the clear value
//   increment     : add one (held at max once reached)
//   count         : current count
//   count_is_max  : count equals the maximum value
module vc_BasicCounter #(
   parameter int p_count_nbits       = 4,
   parameter int p_count_clear_value = 0,
   parameter int p_count_max_value   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     increment,
   output logic [p_count_nbits-1:0] count,
   output logic                     count_is_max
);

   localparam logic [p_count_nbits-1:0] clear_value = p_count_nbits'(p_count_clear_value);
   localparam logic [p_count_nbits-1:0] max_value   = p_count_nbits'(p_count_max_value);

   assign count_is_max = (count == max_value);

   // Clear has priority over increment so a new frame always starts at zero
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= clear_value;
      end else if (increment && !count_is_max) begin
         count <= count + p_count_nbits'(1);
      end
   end

endmodule

// File: rtl/spi_minion.sv
// SPI minion endpoint, mode 0 (CPOL=0, CPHA=0), MSB first.
// Each complete frame of nbits bits is delivered as one parallel word on the
// send val/rdy channel; the word shifted out on miso comes from a one-entry
// transmit buffer filled through the recv val/rdy channel.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : spi_minion_if slave modport (pins, recv/send channels,
//                sticky overflow flag)
module spi_minion #(parameter int nbits = 8) (
   input  logic         clk,
   input  logic         reset,
   spi_minion_if.slave  bus
);

   import spi_pkg::*;

   localparam int cnt_w = $clog2(nbits + 1);
   localparam logic [cnt_w-1:0] last_count = cnt_w'(nbits - 1);

   logic cs_s, cs_rise, cs_fall;
   logic sclk_s, sclk_pos, sclk_neg;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_minion_sync cs_sync (
      .clk(clk), .reset(reset), .din(bus.cs),
      .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   spi_minion_sync sclk_sync (
      .clk(clk), .reset(reset), .din(bus.sclk),
      .sync(sclk_s), .rise(sclk_pos), .fall(sclk_neg)
   );

   spi_minion_sync mosi_sync (
      .clk(clk), .reset(reset), .din(bus.mosi),
      .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   // Only the cs falling edge, the sclk edges and the mosi level drive the
   // frame logic; the remaining synchronizer outputs are intentionally idle.
   logic unused_sync;
   assign unused_sync = &{1'b0, cs_rise, sclk_s, mosi_rise, mosi_fall};

   state_t           state;
   logic [nbits-1:0] rx_shift;
   logic [nbits-1:0] tx_shift;
   logic [nbits-1:0] tx_buf;
   logic             tx_full;
   logic [nbits-1:0] send_msg_r;
   logic             send_val_r;
   logic             overflow_r;
   logic             miso_r;

   logic [cnt_w-1:0] count;
   logic             count_is_max;
   logic             frame_start;
   logic             bit_in;
   logic             frame_done;
   logic [nbits-1:0] rx_word;

   // A frame starts only from IDLE; sclk edges count only while ACTIVE and cs
   // is still low, so an abort (cs high) wins over a coincident edge.
   assign frame_start = (state == IDLE) && cs_fall;
   assign bit_in      = (state == ACTIVE) && !cs_s && sclk_pos;
   assign frame_done  = bit_in && (count == last_count);
   assign rx_word     = {rx_shift[nbits-2:0], mosi_s};

   vc_BasicCounter #(
      .p_count_nbits(cnt_w),
      .p_count_clear_value(0),
      .p_count_max_value(nbits)
   ) bit_counter (
      .clk(clk),
      .reset(reset),
      .clear(frame_start),
      .increment(bit_in),
      .count(count),
      .count_is_max(count_is_max)
   );

   // Frame FSM: shifts rx on sclk rise, tx on sclk fall, and keeps miso
   // registered so it only ever shows the tx MSB while ACTIVE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rx_shift <= '0;
         tx_shift <= '0;
         miso_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state    <= ACTIVE;
                  tx_shift <= tx_full ? tx_buf : '0;
                  miso_r   <= tx_full & tx_buf[nbits-1];
               end
            end
            ACTIVE: begin
               if (cs_s) begin
                  state  <= IDLE;
                  miso_r <= 1'b0;
               end else if (sclk_pos) begin
                  rx_shift <= rx_word;
                  if (count == last_count) begin
                     state  <= HOLD;
                     miso_r <= 1'b0;
                  end
               end else if (sclk_neg) begin
                  tx_shift <= {tx_shift[nbits-2:0], 1'b0};
                  miso_r   <= tx_shift[nbits-2];
               end
            end
            HOLD: begin
               if (cs_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               miso_r <= 1'b0;
            end
         endcase
      end
   end

   // Transmit buffer: emptied when a frame starts (its contents move into the
   // shift register); a handshake in that same cycle refills it for the next
   // frame, since the later assignment wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else begin
         if (frame_start) begin
            tx_full <= 1'b0;
         end
         if (bus.recv_val && !tx_full) begin
            tx_buf  <= bus.recv_msg;
            tx_full <= 1'b1;
         end
      end
   end

   // Receive output: a handshake retires the held word first, so a frame
   // finishing in the same cycle can take its place without an overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         send_msg_r <= '0;
         send_val_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (send_val_r && bus.send_rdy) begin
            send_val_r <= 1'b0;
         end
         if (frame_done) begin
            if (!send_val_r || bus.send_rdy) begin
               send_msg_r <= rx_word;
               send_val_r <= 1'b1;
            end else begin
               overflow_r <= 1'b1;
            end
         end
      end
   end

   assign bus.miso     = miso_r;
   assign bus.recv_rdy = ~tx_full;
   assign bus.send_msg = send_msg_r;
   assign bus.send_val = send_val_r;
   assign bus.overflow = overflow_r;

endmodule
